// File: rtl/mac_pkg.sv
// Shared widths, length encodings, FSM states and the beat-count helper
// for the MAC write issuer.
package mac_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;
    localparam int TAG_W  = 4;
    localparam int ID_W   = 3;
    localparam int LEN_W  = 2;
    localparam int QOS_W  = 4;
    localparam int BEAT_W = DATA_W + MASK_W;

    localparam logic [LEN_W-1:0] LEN_1A = 2'b00;
    localparam logic [LEN_W-1:0] LEN_1B = 2'b01;
    localparam logic [LEN_W-1:0] LEN_2  = 2'b10;
    localparam logic [LEN_W-1:0] LEN_4  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_REQ  = 3'd2,
        ST_WAIT = 3'd3,
        ST_DATA = 3'd4
    } wr_state_e;

    function automatic logic [2:0] beats_of(input logic [LEN_W-1:0] len);
        case (len)
            LEN_2:   beats_of = 3'd2;
            LEN_4:   beats_of = 3'd4;
            default: beats_of = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/mac_wr_beat_fifo.sv
// Synchronous beat buffer holding {mask, data} entries; head is visible
// combinationally so a pop can register it in the same cycle.
module mac_wr_beat_fifo
    import mac_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clr_i,
    input  logic                          push_i,
    input  logic [BEAT_W-1:0]             push_beat_i,
    input  logic                          pop_i,
    output logic [BEAT_W-1:0]             head_o,
    output logic [$clog2(DEPTH+1)-1:0]    count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [BEAT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    // Storage array; contents only matter while counted as valid.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_beat_i;
        end
    end

    // Pointers and occupancy, wrapping explicitly for non-power-of-two depths.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/mac_wr_issuer.sv
// Write master for the MAC write channel: buffers one command plus its beats, pulses the
// request, waits for ReadyWr, then streams the beats. MAC_WR_TIMEOUT_EN adds a ReadyWr watchdog.
module mac_wr_issuer
    import mac_pkg::*;
#(
    parameter int BUF_DEPTH = 4,
    parameter int TO_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iCmd_Valid,
    output logic              oCmd_Ready,
    input  logic [ADDR_W-1:0] iCmd_Addr,
    input  logic [LEN_W-1:0]  iCmd_Len,
    input  logic [ID_W-1:0]   iCmd_Id,
    input  logic [QOS_W-1:0]  iCmd_QoS,
    input  logic              iDat_Valid,
    output logic              oDat_Ready,
    input  logic [DATA_W-1:0] iDat_Data,
    input  logic [MASK_W-1:0] iDat_Mask,
    output logic              oMAC_ValidWr,
    output logic [ADDR_W-1:0] oMAC_AddrWr,
    output logic [TAG_W-1:0]  oMAC_TagWr,
    output logic [ID_W-1:0]   oMAC_IdWr,
    output logic [LEN_W-1:0]  oMAC_LenWr,
    output logic [QOS_W-1:0]  oMAC_QoSWr,
    input  logic              iMAC_ReadyWr,
    output logic [DATA_W-1:0] oMAC_DataWr,
    output logic [MASK_W-1:0] oMAC_MaskWr,
    output logic              oMAC_EoD,
    output logic              oBusy,
    output logic              oTimeout
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    wr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [QOS_W-1:0]  qos_q, qos_d;
    logic [2:0]        beats_q, beats_d;
    logic [2:0]        idx_q, idx_d;
    logic [TAG_W-1:0]  tag_q, tag_d;

    logic              cmd_rdy_q, cmd_rdy_d;
    logic              dat_rdy_q, dat_rdy_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] mac_addr_q, mac_addr_d;
    logic [TAG_W-1:0]  mac_tag_q, mac_tag_d;
    logic [ID_W-1:0]   mac_id_q, mac_id_d;
    logic [LEN_W-1:0]  mac_len_q, mac_len_d;
    logic [QOS_W-1:0]  mac_qos_q, mac_qos_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [MASK_W-1:0] mask_q, mask_d;
    logic              eod_q, eod_d;
    logic              busy_q, busy_d;

    logic              push_s, pop_s, clr_s, last_beat_s;
    logic [BEAT_W-1:0] head_s;
    logic [CNT_W-1:0]  fifo_cnt_s;

`ifdef MAC_WR_TIMEOUT_EN
    localparam int TO_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              timeout_q, timeout_d;
`endif

    mac_wr_beat_fifo #(
        .DEPTH(BUF_DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_i       (reset),
        .clr_i       (clr_s),
        .push_i      (push_s),
        .push_beat_i ({iDat_Mask, iDat_Data}),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .count_o     (fifo_cnt_s)
    );

    assign last_beat_s = ((32'(fifo_cnt_s) + 32'd1) == 32'(beats_q));

    // Next-state logic; every output register is derived from the state being entered.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        id_d    = id_q;
        qos_d   = qos_q;
        beats_d = beats_q;
        idx_d   = idx_q;
        tag_d   = tag_q;
        data_d  = '0;
        mask_d  = '0;
        eod_d   = 1'b0;
        push_s  = 1'b0;
        pop_s   = 1'b0;
        clr_s   = 1'b0;
`ifdef MAC_WR_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (iCmd_Valid && cmd_rdy_q) begin
                    addr_d  = iCmd_Addr;
                    len_d   = iCmd_Len;
                    id_d    = iCmd_Id;
                    qos_d   = iCmd_QoS;
                    beats_d = beats_of(iCmd_Len);
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (iDat_Valid && dat_rdy_q) begin
                    push_s  = 1'b1;
                    state_d = last_beat_s ? ST_REQ : ST_LOAD;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_REQ, ST_WAIT: begin
                if (state_q == ST_REQ) begin
                    tag_d = tag_q + TAG_W'(1);
                end else begin
                    tag_d = tag_q;
                end
`ifdef MAC_WR_TIMEOUT_EN
                to_cnt_d = (state_q == ST_REQ) ? '0 : to_cnt_q + TO_W'(1);
`endif
                if (iMAC_ReadyWr) begin
                    pop_s            = 1'b1;
                    {mask_d, data_d} = head_s;
                    eod_d            = (beats_q == 3'd1);
                    idx_d            = 3'd0;
                    state_d          = ST_DATA;
`ifdef MAC_WR_TIMEOUT_EN
                end else if (state_q == ST_WAIT && to_cnt_q == TO_W'(TO_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    clr_s     = 1'b1;
                    state_d   = ST_IDLE;
`endif
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DATA: begin
                // idx_q == beats_q marks the trailing all-zero cycle before IDLE.
                if (idx_q < beats_q - 3'd1) begin
                    pop_s            = 1'b1;
                    {mask_d, data_d} = head_s;
                    eod_d            = ((idx_q + 3'd2) == beats_q);
                    idx_d            = idx_q + 3'd1;
                end else if (idx_q == beats_q - 3'd1) begin
                    idx_d = beats_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cmd_rdy_d = (state_d == ST_IDLE);
        dat_rdy_d = (state_d == ST_LOAD);
        busy_d    = (state_d != ST_IDLE);
        valid_d   = (state_d == ST_REQ);
        if (valid_d) begin
            mac_addr_d = addr_q;
            mac_tag_d  = tag_q;
            mac_id_d   = id_q;
            mac_len_d  = len_q;
            mac_qos_d  = qos_q;
        end else begin
            mac_addr_d = '0;
            mac_tag_d  = '0;
            mac_id_d   = '0;
            mac_len_d  = '0;
            mac_qos_d  = '0;
        end
    end

    // State, command context and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            id_q       <= '0;
            qos_q      <= '0;
            beats_q    <= '0;
            idx_q      <= '0;
            tag_q      <= '0;
            cmd_rdy_q  <= 1'b0;
            dat_rdy_q  <= 1'b0;
            valid_q    <= 1'b0;
            mac_addr_q <= '0;
            mac_tag_q  <= '0;
            mac_id_q   <= '0;
            mac_len_q  <= '0;
            mac_qos_q  <= '0;
            data_q     <= '0;
            mask_q     <= '0;
            eod_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            id_q       <= id_d;
            qos_q      <= qos_d;
            beats_q    <= beats_d;
            idx_q      <= idx_d;
            tag_q      <= tag_d;
            cmd_rdy_q  <= cmd_rdy_d;
            dat_rdy_q  <= dat_rdy_d;
            valid_q    <= valid_d;
            mac_addr_q <= mac_addr_d;
            mac_tag_q  <= mac_tag_d;
            mac_id_q   <= mac_id_d;
            mac_len_q  <= mac_len_d;
            mac_qos_q  <= mac_qos_d;
            data_q     <= data_d;
            mask_q     <= mask_d;
            eod_q      <= eod_d;
            busy_q     <= busy_d;
        end
    end

`ifdef MAC_WR_TIMEOUT_EN
    // ReadyWr watchdog counter and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign oTimeout = timeout_q;
`else
    assign oTimeout = 1'b0;
`endif

    assign oCmd_Ready   = cmd_rdy_q;
    assign oDat_Ready   = dat_rdy_q;
    assign oMAC_ValidWr = valid_q;
    assign oMAC_AddrWr  = mac_addr_q;
    assign oMAC_TagWr   = mac_tag_q;
    assign oMAC_IdWr    = mac_id_q;
    assign oMAC_LenWr   = mac_len_q;
    assign oMAC_QoSWr   = mac_qos_q;
    assign oMAC_DataWr  = data_q;
    assign oMAC_MaskWr  = mask_q;
    assign oMAC_EoD     = eod_q;
    assign oBusy        = busy_q;

endmodule

// File: tb/tb_mac_wr_issuer.sv
// Directed self-checking bench for mac_wr_issuer.
module tb_mac_wr_issuer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        iCmd_Valid = 1'b0;
    logic        oCmd_Ready;
    logic [31:0] iCmd_Addr = 32'h0;
    logic [1:0]  iCmd_Len = 2'b00;
    logic [2:0]  iCmd_Id = 3'd0;
    logic [3:0]  iCmd_QoS = 4'd0;
    logic        iDat_Valid = 1'b0;
    logic        oDat_Ready;
    logic [31:0] iDat_Data = 32'h0;
    logic [3:0]  iDat_Mask = 4'h0;
    logic        oMAC_ValidWr;
    logic [31:0] oMAC_AddrWr;
    logic [3:0]  oMAC_TagWr;
    logic [2:0]  oMAC_IdWr;
    logic [1:0]  oMAC_LenWr;
    logic [3:0]  oMAC_QoSWr;
    logic        iMAC_ReadyWr = 1'b0;
    logic [31:0] oMAC_DataWr;
    logic [3:0]  oMAC_MaskWr;
    logic        oMAC_EoD;
    logic        oBusy;
    logic        oTimeout;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [3:0]  exp_tag = 4'd0;
    logic [31:0] bd [4];
    logic [3:0]  bm [4];

    always #5 clk = ~clk;

    mac_wr_issuer #(.BUF_DEPTH(4), .TO_CYCLES(64)) dut (
        .clk(clk), .reset(reset),
        .iCmd_Valid(iCmd_Valid), .oCmd_Ready(oCmd_Ready), .iCmd_Addr(iCmd_Addr),
        .iCmd_Len(iCmd_Len), .iCmd_Id(iCmd_Id), .iCmd_QoS(iCmd_QoS),
        .iDat_Valid(iDat_Valid), .oDat_Ready(oDat_Ready), .iDat_Data(iDat_Data),
        .iDat_Mask(iDat_Mask),
        .oMAC_ValidWr(oMAC_ValidWr), .oMAC_AddrWr(oMAC_AddrWr), .oMAC_TagWr(oMAC_TagWr),
        .oMAC_IdWr(oMAC_IdWr), .oMAC_LenWr(oMAC_LenWr), .oMAC_QoSWr(oMAC_QoSWr),
        .iMAC_ReadyWr(iMAC_ReadyWr), .oMAC_DataWr(oMAC_DataWr), .oMAC_MaskWr(oMAC_MaskWr),
        .oMAC_EoD(oMAC_EoD), .oBusy(oBusy), .oTimeout(oTimeout)
    );

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    function automatic int nbeats(input logic [1:0] l);
        case (l)
            2'b10:   return 2;
            2'b11:   return 4;
            default: return 1;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic [31:0] a, input logic [1:0] l, input logic [2:0] id, input logic [3:0] q);
        int k = 0;
        iCmd_Valid = 1'b1; iCmd_Addr = a; iCmd_Len = l; iCmd_Id = id; iCmd_QoS = q;
        while (!oCmd_Ready && k < 20) begin
            tick();
            k++;
        end
        if (k == 20) expect_eq("cmd_ready_bound", oCmd_Ready, 1);
        tick();
        iCmd_Valid = 1'b0; iCmd_Addr = 32'h0; iCmd_Len = 2'b00; iCmd_Id = 3'd0; iCmd_QoS = 4'd0;
    endtask

    task automatic do_beat(input logic [31:0] d, input logic [3:0] m, input int gap);
        int k = 0;
        repeat (gap) tick();
        iDat_Valid = 1'b1; iDat_Data = d; iDat_Mask = m;
        while (!oDat_Ready && k < 20) begin
            tick();
            k++;
        end
        if (k == 20) expect_eq("dat_ready_bound", oDat_Ready, 1);
        tick();
        iDat_Valid = 1'b0; iDat_Data = 32'h0; iDat_Mask = 4'h0;
    endtask

    // Called in the REQ cycle; drives ReadyWr d cycles after the pulse and checks the stream.
    task automatic run_mac(input logic [31:0] a, input logic [1:0] l, input logic [2:0] id,
                           input logic [3:0] q, input int d);
        int n = nbeats(l);
        expect_eq("req_valid", oMAC_ValidWr, 1);
        expect_eq("req_addr", oMAC_AddrWr, a);
        expect_eq("req_len", oMAC_LenWr, l);
        expect_eq("req_id", oMAC_IdWr, id);
        expect_eq("req_qos", oMAC_QoSWr, q);
        expect_eq("req_tag", oMAC_TagWr, exp_tag);
        exp_tag = exp_tag + 4'd1;
        if (d == 0) iMAC_ReadyWr = 1'b1;
        tick();
        expect_eq("req_one_cycle", oMAC_ValidWr, 0);
        expect_eq("req_fields_clear", {oMAC_AddrWr, oMAC_TagWr, oMAC_QoSWr}, 0);
        if (d > 0) begin
            for (int i = 1; i < d; i++) begin
                expect_eq("wait_no_data", {oMAC_EoD, oMAC_MaskWr, oMAC_DataWr}, 0);
                tick();
            end
            iMAC_ReadyWr = 1'b1;
            tick();
        end
        iMAC_ReadyWr = 1'b0;
        for (int k = 0; k < n; k++) begin
            expect_eq("beat_data", oMAC_DataWr, bd[k]);
            expect_eq("beat_mask", oMAC_MaskWr, bm[k]);
            expect_eq("beat_eod", oMAC_EoD, (k == n - 1));
            tick();
        end
        expect_eq("post_zero", {oMAC_EoD, oMAC_MaskWr, oMAC_DataWr}, 0);
        expect_eq("post_busy", oBusy, 1);
        tick();
        expect_eq("idle_busy", oBusy, 0);
        expect_eq("idle_cmd_ready", oCmd_Ready, 1);
    endtask

    task automatic write_burst(input logic [31:0] a, input logic [1:0] l, input logic [2:0] id,
                               input logic [3:0] q, input int d, input int gap);
        int n = nbeats(l);
        do_cmd(a, l, id, q);
        expect_eq("busy_after_cmd", oBusy, 1);
        for (int k = 0; k < n; k++) begin
            do_beat(bd[k], bm[k], gap);
            if (k < n - 1) expect_eq("no_req_before_full", oMAC_ValidWr, 0);
        end
        run_mac(a, l, id, q, d);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        exp_tag = 4'd0;
    endtask

    initial begin
        #1;
        expect_eq("rst_outputs", {oCmd_Ready, oDat_Ready, oMAC_ValidWr, oMAC_EoD, oBusy, oTimeout}, 0);
        expect_eq("rst_fields", {oMAC_AddrWr, oMAC_TagWr, oMAC_DataWr}, 0);
        tick();
        reset = 1'b0;
        tick();
        expect_eq("idle_cmd_ready", oCmd_Ready, 1);

        // Data offered in IDLE must not be taken.
        iDat_Valid = 1'b1; iDat_Data = 32'hDEAD_BEEF; iDat_Mask = 4'hF;
        expect_eq("idle_dat_ready", oDat_Ready, 0);
        tick();
        iDat_Valid = 1'b0;

        // 1: two beats, ReadyWr three cycles after the pulse.
        bd[0] = 32'hABCD_EF12; bm[0] = 4'b1101;
        bd[1] = 32'hCBCD_EF12; bm[1] = 4'b1011;
        write_burst(32'h2345_F220, 2'b10, 3'd5, 4'd6, 3, 0);

        // 2: four beats with gaps on the data side.
        bd[0] = 32'h1111_0001; bm[0] = 4'h1;
        bd[1] = 32'h2222_0002; bm[1] = 4'h3;
        bd[2] = 32'h3333_0003; bm[2] = 4'h7;
        bd[3] = 32'h4444_0004; bm[3] = 4'hF;
        write_burst(32'h0000_1000, 2'b11, 3'd2, 4'd9, 1, 2);

        // 3: ReadyWr already high in the REQ cycle.
        bd[0] = 32'h5A5A_A5A5; bm[0] = 4'hC;
        bd[1] = 32'h0F0F_F0F0; bm[1] = 4'h3;
        write_burst(32'h8000_0040, 2'b10, 3'd7, 4'd15, 0, 0);

        // 4: 17 single-beat writes; tag wraps 15 -> 0.
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            bd[0] = 32'hC000_0000 + 32'(i);
            bm[0] = 4'(i);
            write_burst(32'(i) * 32'h100, (i % 2 == 0) ? 2'b00 : 2'b01, 3'(i), 4'(i), 0, 0);
        end

        // 5: reset during beat 1 of a four-beat burst.
        bd[0] = 32'hAAAA_0000; bm[0] = 4'hF;
        bd[1] = 32'hAAAA_0001; bm[1] = 4'hE;
        bd[2] = 32'hAAAA_0002; bm[2] = 4'hD;
        bd[3] = 32'hAAAA_0003; bm[3] = 4'hC;
        do_cmd(32'h0000_2000, 2'b11, 3'd1, 4'd1);
        for (int k = 0; k < 4; k++) do_beat(bd[k], bm[k], 0);
        expect_eq("rst_case_req", oMAC_ValidWr, 1);
        iMAC_ReadyWr = 1'b1;
        tick();
        iMAC_ReadyWr = 1'b0;
        expect_eq("rst_case_beat0", oMAC_DataWr, bd[0]);
        tick();
        expect_eq("rst_case_beat1", oMAC_DataWr, bd[1]);
        #2;
        reset = 1'b1;
        #1;
        expect_eq("midburst_rst_data", {oMAC_EoD, oMAC_MaskWr, oMAC_DataWr}, 0);
        expect_eq("midburst_rst_ctrl", {oBusy, oCmd_Ready, oDat_Ready, oMAC_ValidWr}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        exp_tag = 4'd0;
        bd[0] = 32'h7777_0007; bm[0] = 4'h5;
        write_burst(32'h0000_3000, 2'b00, 3'd3, 4'd4, 0, 0);

`ifdef MAC_WR_TIMEOUT_EN
        // 6: ReadyWr never comes; flag rises after 64 WAIT cycles.
        begin
            int t;
            apply_reset();
            do_cmd(32'h0000_4000, 2'b00, 3'd0, 4'd0);
            do_beat(32'h1234_5678, 4'hF, 0);
            expect_eq("to_req", oMAC_ValidWr, 1);
            exp_tag = exp_tag + 4'd1;
            t = 0;
            while (!oTimeout && t < 100) begin
                tick();
                t++;
            end
            expect_eq("to_cycle", t, 65);
            expect_eq("to_idle", oBusy, 0);
            tick();
            expect_eq("to_sticky", oTimeout, 1);
            bd[0] = 32'h9999_0009; bm[0] = 4'hA;
            write_burst(32'h0000_5000, 2'b00, 3'd1, 4'd2, 0, 0);
        end
`else
        expect_eq("timeout_tied", oTimeout, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, got hang, want finish");
        $fatal(1);
    end

endmodule
